sop_pos_sweep_checker: RTL and testbench

- Sequential sweep/compare stage that drives all 16 input combinations into a combinational 4-input boolean block with SOP and POS outputs, and consumes its two results.
- Builds a 16-bit truth-table map for each form, counts SOP/POS disagreements and records the first failing minterm.
- Sits beside the combinational block in the guide's test harness. Drives x, y, w, z into it and reads f_sop, f_pos back.

---
 rtl/sop_pos_sweep_checker.sv | 145 ++++++++++++++
 tb/tb_sop_pos_sweep_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_pos_sweep_checker.sv
// Sweeps all 16 {x,y,w,z} combinations into an external SOP/POS block, builds both truth-table maps,
// counts SOP/POS disagreements and records the first one. Optional golden compare: EXPECT_CHECK_EN.
module sop_pos_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter logic [15:0] EXPECTED_MAP  = 16'h9527
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    input  logic        f_sop_in,
    input  logic        f_pos_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] sop_map,
    output logic [15:0] pos_map,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_mismatch,
    output logic        expect_fail
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    // WAIT lasts SETTLE_CYCLES cycles; with no settle time WAIT is never entered.
    localparam bit         HAS_WAIT    = (SETTLE_CYCLES != 0);
    localparam logic [3:0] SETTLE_LAST = HAS_WAIT ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_idx;
    logic [3:0]  r_settle;
    logic [15:0] r_sop_map;
    logic [15:0] r_pos_map;
    logic [4:0]  r_mcount;
    logic [3:0]  r_first;
    logic [15:0] w_sop_next;
    logic [15:0] w_pos_next;
    logic        w_diff;

    always_comb begin
        w_sop_next        = r_sop_map;
        w_pos_next        = r_pos_map;
        w_sop_next[r_idx] = f_sop_in;
        w_pos_next[r_idx] = f_pos_in;
        w_diff            = f_sop_in ^ f_pos_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = HAS_WAIT ? S_WAIT : S_SAMPLE;
            S_WAIT:   if (r_settle == SETTLE_LAST) w_next = S_SAMPLE;
            S_SAMPLE: begin
                if (r_idx == 4'hF) begin
                    w_next = S_DONE;
                end else begin
                    w_next = HAS_WAIT ? S_WAIT : S_SAMPLE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_WAIT) || (r_state == S_SAMPLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= 4'd0;
            r_settle  <= 4'd0;
            r_sop_map <= 16'd0;
            r_pos_map <= 16'd0;
            r_mcount  <= 5'd0;
            r_first   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx     <= 4'd0;
                        r_settle  <= 4'd0;
                        r_sop_map <= 16'd0;
                        r_pos_map <= 16'd0;
                        r_mcount  <= 5'd0;
                        r_first   <= 4'd0;
                    end
                end
                S_WAIT: r_settle <= r_settle + 4'd1;
                S_SAMPLE: begin
                    r_sop_map <= w_sop_next;
                    r_pos_map <= w_pos_next;
                    if (w_diff) begin
                        r_mcount <= r_mcount + 5'd1;
                        if (r_mcount == 5'd0) r_first <= r_idx;
                    end
                    // idx parks at 15 after the last sample so it never wraps.
                    if (r_idx != 4'hF) begin
                        r_idx    <= r_idx + 4'd1;
                        r_settle <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {x, y, w, z}   = r_idx;
    assign sop_map        = r_sop_map;
    assign pos_map        = r_pos_map;
    assign mismatch_count = r_mcount;
    assign first_mismatch = r_first;

`ifdef EXPECT_CHECK_EN
    logic r_expect_fail;

    // The final maps include the idx-15 bit captured on the same edge, hence the *_next values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expect_fail <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_expect_fail <= 1'b0;
        end else if ((r_state == S_SAMPLE) && (r_idx == 4'hF)) begin
            r_expect_fail <= (w_sop_next != EXPECTED_MAP) || (w_pos_next != EXPECTED_MAP);
        end
    end

    assign expect_fail = r_expect_fail;
`else
    assign expect_fail = 1'b0 & (^EXPECTED_MAP);
`endif

endmodule

// File: tb/tb_sop_pos_sweep_checker.sv
// Scoreboard bench for sop_pos_sweep_checker: one DUT with no settle time, one with SETTLE_CYCLES=3.
module tb_sop_pos_sweep_checker;

`ifdef EXPECT_CHECK_EN
    localparam bit EF_ON = 1'b1;
`else
    localparam bit EF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sop;
        logic [15:0] pos;
        logic [4:0]  cnt;
        logic [3:0]  first;
        logic        ef;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int dn0 = 0;
    int dn3 = 0;
    exp_t q0[$];
    exp_t q3[$];

    logic [15:0] lut_sop = 16'h9527;
    logic [15:0] lut_pos = 16'hFE97;

    // DUT with SETTLE_CYCLES=0
    logic        start0 = 1'b0;
    logic        x0, y0, w0, z0, sop_in0, pos_in0, busy0, done0, ef0;
    logic [15:0] smap0, pmap0;
    logic [4:0]  cnt0;
    logic [3:0]  first0;
    logic [3:0]  idx0;
    int          mode0 = 0;

    always_comb begin
        idx0    = {x0, y0, w0, z0};
        sop_in0 = 1'b0;
        pos_in0 = 1'b0;
        case (mode0)
            0: begin sop_in0 = lut_sop[idx0]; pos_in0 = lut_pos[idx0]; end
            1: begin sop_in0 = x0 ^ z0;       pos_in0 = x0 ^ z0;       end
            2: begin sop_in0 = 1'b1;          pos_in0 = 1'b0;          end
            default: begin sop_in0 = lut_sop[idx0]; pos_in0 = lut_sop[idx0]; end
        endcase
    end

    sop_pos_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED_MAP(16'h9527)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .x(x0), .y(y0), .w(w0), .z(z0),
        .f_sop_in(sop_in0), .f_pos_in(pos_in0),
        .busy(busy0), .done(done0),
        .sop_map(smap0), .pos_map(pmap0),
        .mismatch_count(cnt0), .first_mismatch(first0),
        .expect_fail(ef0)
    );

    // DUT with SETTLE_CYCLES=3, fed by a block whose output lags idx by two cycles
    logic        start3 = 1'b0;
    logic        x3, y3, w3, z3, busy3, done3, ef3;
    logic [15:0] smap3, pmap3;
    logic [4:0]  cnt3;
    logic [3:0]  first3;
    logic [3:0]  idx3_d1 = 4'd0;
    logic [3:0]  idx3_d2 = 4'd0;
    logic        sop_in3, pos_in3;

    always @(posedge clk) begin
        idx3_d1 <= {x3, y3, w3, z3};
        idx3_d2 <= idx3_d1;
    end
    assign sop_in3 = lut_sop[idx3_d2];
    assign pos_in3 = lut_pos[idx3_d2];

    sop_pos_sweep_checker #(.SETTLE_CYCLES(3), .EXPECTED_MAP(16'h9527)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .x(x3), .y(y3), .w(w3), .z(z3),
        .f_sop_in(sop_in3), .f_pos_in(pos_in3),
        .busy(busy3), .done(done3),
        .sop_map(smap3), .pos_map(pmap3),
        .mismatch_count(cnt3), .first_mismatch(first3),
        .expect_fail(ef3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit d3, input logic [15:0] s, input logic [15:0] p,
                        input logic [4:0] c, input logic [3:0] f, input logic ef);
        exp_t e;
        e.sop = s; e.pos = p; e.cnt = c; e.first = f; e.ef = ef & EF_ON;
        if (d3) q3.push_back(e);
        else    q0.push_back(e);
    endtask

    always @(negedge clk) begin
        if (done0) begin
            dn0++;
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL d0_unexpected_done: done seen with empty scoreboard");
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("d0_sop_map", smap0, e.sop);
                chk("d0_pos_map", pmap0, e.pos);
                chk("d0_mismatch_count", cnt0, e.cnt);
                chk("d0_first_mismatch", first0, e.first);
                chk("d0_expect_fail", ef0, e.ef);
            end
        end
        if (done3) begin
            dn3++;
            if (q3.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL d3_unexpected_done: done seen with empty scoreboard");
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("d3_sop_map", smap3, e.sop);
                chk("d3_pos_map", pmap3, e.pos);
                chk("d3_mismatch_count", cnt3, e.cnt);
                chk("d3_first_mismatch", first3, e.first);
                chk("d3_expect_fail", ef3, e.ef);
            end
        end
    end

    // Issue start, check the clear on the accepting edge, then measure latency and busy time.
    task automatic sweep(input bit d3, input int exp_lat, input logic [15:0] hold_sop);
        int k;
        int busyc;
        bit got;
        @(negedge clk);
        if (d3) start3 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start3 = 1'b0;
        chk("start_idx", d3 ? {x3, y3, w3, z3} : idx0, 4'd0);
        chk("start_clr_cnt", d3 ? cnt3 : cnt0, 5'd0);
        chk("start_clr_sop", d3 ? smap3 : smap0, 16'd0);
        chk("start_clr_ef", d3 ? ef3 : ef0, 1'b0);
        k = 0; busyc = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (d3 ? done3 : done0) begin got = 1'b1; break; end
            if (d3 ? busy3 : busy0) busyc++;
        end
        chk("latency", got ? k : 0, exp_lat);
        chk("busy_cycles", busyc, exp_lat - 1);
        repeat (2) @(negedge clk);
        chk("hold_sop", d3 ? smap3 : smap0, hold_sop);
        chk("idle_busy", d3 ? busy3 : busy0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idx0", idx0, 4'd0);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_done0", done0, 1'b0);
        chk("rst_sop0", smap0, 16'd0);
        chk("rst_cnt0", cnt0, 5'd0);
        chk("rst_ef0", ef0, 1'b0);
        chk("rst_busy3", busy3, 1'b0);
        chk("rst_sop3", smap3, 16'd0);
        reset = 1'b0;

        // Guide block: 9527 ^ FE97 = 6BB0 -> 8 differences, lowest at index 4.
        mode0 = 0;
        push(0, 16'h9527, 16'hFE97, 5'd8, 4'd4, 1'b1);
        sweep(0, 17, 16'h9527);

        // x^z is 1 where idx bit3 != bit0: indices 1,3,5,7,8,10,12,14.
        mode0 = 1;
        push(0, 16'h55AA, 16'h55AA, 5'd0, 4'd0, 1'b1);
        sweep(0, 17, 16'h55AA);

        // Every index disagrees: count reaches 16 without wrapping, first at 0.
        mode0 = 2;
        push(0, 16'hFFFF, 16'h0000, 5'd16, 4'd0, 1'b1);
        sweep(0, 17, 16'hFFFF);

        // Both forms from the golden table; also clears a set expect_fail on start.
        mode0 = 3;
        push(0, 16'h9527, 16'h9527, 5'd0, 4'd0, 1'b0);
        sweep(0, 17, 16'h9527);

        // Settle-time DUT: 16*(3+1)+1 cycles to done, 64 busy.
        push(1, 16'h9527, 16'hFE97, 5'd8, 4'd4, 1'b1);
        sweep(1, 65, 16'h9527);

        // Reset mid-sweep at idx 7, with start also high: reset wins.
        mode0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (idx0 == 4'd7) begin hit = 1'b1; break; end
            end
            chk("reach_idx7", hit ? idx0 : 4'd0, 4'd7);
        end
        reset = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start0 = 1'b0;
        chk("mid_rst_idx", idx0, 4'd0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_done", done0, 1'b0);
        chk("mid_rst_sop", smap0, 16'd0);
        chk("mid_rst_pos", pmap0, 16'd0);
        chk("mid_rst_cnt", cnt0, 5'd0);
        chk("mid_rst_first", first0, 4'd0);
        chk("mid_rst_ef", ef0, 1'b0);
        @(negedge clk);
        chk("mid_rst_still_idle", busy0, 1'b0);
        push(0, 16'h9527, 16'hFE97, 5'd8, 4'd4, 1'b1);
        sweep(0, 17, 16'h9527);

        // Start toggled throughout the sweep and held during DONE: one sweep only.
        push(0, 16'h9527, 16'hFE97, 5'd8, 4'd4, 1'b1);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        begin
            int k;
            bit got;
            k = 0; got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                k++;
                if (done0) begin got = 1'b1; break; end
                start0 = ~start0;
            end
            chk("rep_latency", got ? k : 0, 17);
        end
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rep_no_restart", busy0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("d0_done_pulses", dn0, 6);
        chk("d3_done_pulses", dn3, 1);
        chk("d0_queue_left", q0.size(), 0);
        chk("d3_queue_left", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
